vga_sync_receiver: RTL and testbench
====================================

// Module: vga_sync_receiver
// PURPOSE
//  Receive end of the 640x480@60 VGA interface: samples HSYNC/VSYNC/RGB as produced by the
//  on-chip VGA driver, recovers pixel coordinates, measures line/frame timing, tracks lock.
//  Sits in the self-check harness beside the pattern tests; its probe port lets a bench or
//  on-board logic read back one chosen pixel's colour per frame.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line | H_SYNC 96 hsync width | H_BP 48 back porch | H_TOTAL 800 clocks/line
//  V_ACTIVE 480 visible lines | V_SYNC 2 vsync lines | V_BP 33 back porch | V_TOTAL 525 lines/frame
//  SYNC_ACT 0 active level of both syncs (0 = negative polarity)
//  LOCK_FRAMES 2 consecutive good frames required to declare lock
// PORTS
//  clk_vga      in   1   25 MHz pixel clock (same domain as the driver)
//  rst_n        in   1   asynchronous reset, active low
//  vga_hsync    in   1   horizontal sync
//  vga_vsync    in   1   vertical sync
//  vga_r/g/b    in   4   colour channels (each 4 bits)
//  probe_x      in   10  probe column
//  probe_y      in   10  probe row
//  clr_err      in   1   synchronous clear of err sticky flag
//  rx_x         out  10  recovered column of current output pixel
//  rx_y         out  10  recovered row of current output pixel
//  rx_de        out  1   output pixel is visible AND locked
//  rx_rgb       out  12  {r,g,b} of current output pixel
//  locked       out  1   lock FSM in LOCKED
//  line_len     out  10  clocks measured in last complete line
//  frame_lines  out  10  lines measured in last complete frame
//  probe_rgb    out  12  colour captured at (probe_x,probe_y)
//  probe_hit    out  1   one-cycle pulse when probe_rgb updates
//  err          out  1   sticky: bad line, bad frame or sync loss since last clr_err
// BEHAVIOUR
//  Reset: all outputs and state 0; FSM = SEARCH; h_cnt saturated (1023).
//  Stage 1 registers all pins; stage 2 registers outputs -> rx_* lag pins by exactly 2 clocks.
//  hs_lead = stage-1 hsync at SYNC_ACT and previous not; vs_lead likewise for vsync.
//  h_cnt: 0 on hs_lead, else +1 saturating at 1023.
//  Horizontal window: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1]; rx_x = h_cnt-(H_SYNC+H_BP).
//  On hs_lead: line_len <= h_cnt+1 (skip if h_cnt saturated); line bad if != H_TOTAL.
//  vs_pend set on vs_lead, cleared on next hs_lead (same-cycle vs_lead+hs_lead counts).
//  v_cnt: on hs_lead, 0 if vs_pend|vs_lead, else +1 saturating at 1023.
//  Vertical window: v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1]; rx_y = v_cnt-(V_SYNC+V_BP).
//  Frame boundary = hs_lead resetting v_cnt: frame_lines <= v_cnt+1; frame good iff
//  == V_TOTAL and no bad line since previous boundary.
//  Outside either window rx_x/rx_y hold 0 and rx_rgb = 0.
//  Lock FSM (evaluated at frame boundaries, and on bad line / sync loss at any time):
//   SEARCH  -> ACQUIRE at first boundary (good-frame count = 0; first partial frame never counts)
//   ACQUIRE -> good frame: count+1; count reaches LOCK_FRAMES -> LOCKED; bad frame -> SEARCH
//   LOCKED  -> bad line, bad frame or sync loss -> SEARCH (locked drops next clock)
//  Sync loss: h_cnt reaches 1023 (no hsync for 1023 clocks) -> SEARCH.
//  err set on any bad line/frame/sync loss while not SEARCH; clr_err clears; set wins over clear.
//  Probe: when rx_de and rx_x==probe_x and rx_y==probe_y, probe_rgb <= rx_rgb and probe_hit=1
//   for that one cycle; at most one hit per frame. Out-of-range probe never hits.
//  rst_n low mid-frame: immediate return to reset state; relock needs full LOCK_FRAMES again.
// TESTING
//  1 Drive nominal 640x480 timing, constant 0xF0F -> locked rises at 3rd frame boundary; line_len=800, frame_lines=525.
//  2 Locked, pixel (0,0) = 0x123 -> rx_x=0,rx_y=0,rx_de=1,rx_rgb=0x123 exactly 2 clocks after pins; (639,479) likewise, x=640 -> rx_de=0.
//  3 Locked, one line 801 clocks -> line_len=801, locked=0 next clock, err=1; clr_err alone keeps err 0 after.
//  4 Hold hsync inactive 1100 clocks while locked -> SEARCH at h_cnt=1023, err=1; resume -> relock after 2 good frames.
//  5 probe=(200,200), pixel 0xABC there -> probe_hit one pulse per frame, probe_rgb=0xABC; probe=(700,0) -> no hit.
//  6 rst_n low mid-frame 3 clocks -> all outputs 0 asynchronously; locked re-asserts only after 2 further good frames.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// VGA receive front end: re-times sync/colour pins, recovers the raster position,
// measures line/frame timing, tracks lock and captures one probe pixel per frame.
module vga_sync_receiver #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_TOTAL     = 525,
  parameter bit          SYNC_ACT    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  input  logic        clr_err,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_de,
  output logic [11:0] rx_rgb,
  output logic        locked,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic [11:0] probe_rgb,
  output logic        probe_hit,
  output logic        err
);

  localparam int unsigned CW    = 10;
  localparam int unsigned RGB_W = 12;
  localparam int unsigned GC_W  = $clog2(LOCK_FRAMES + 1);

  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam logic [CW-1:0]   H_FIRST = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0]   H_LAST  = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CW-1:0]   V_FIRST = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0]   V_LAST  = CW'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [CW-1:0]   H_LEN   = CW'(H_TOTAL);
  localparam logic [CW-1:0]   V_LEN   = CW'(V_TOTAL);
  localparam logic [GC_W-1:0] GC_LOCK = GC_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} lock_state_e;

  lock_state_e      state, state_nxt;
  logic [GC_W-1:0]  good_cnt, good_cnt_nxt;
  logic             s1_hs, s1_vs, s1_hs_d, s1_vs_d;
  logic [RGB_W-1:0] s1_rgb;
  logic [CW-1:0]    h_cnt, v_cnt;
  logic             vs_pend, bad_seen, probe_done;

  logic             hs_lead, vs_lead, h_sat, v_sat, frame_start;
  logic             line_bad, frame_good, sync_loss, in_win, err_evt;
  logic [CW-1:0]    h_cur, v_cur, h_meas, v_meas;

  // Sync edge detection and position of the pixel currently in stage 1
  assign hs_lead     = (s1_hs == SYNC_ACT) && (s1_hs_d != SYNC_ACT);
  assign vs_lead     = (s1_vs == SYNC_ACT) && (s1_vs_d != SYNC_ACT);
  assign h_sat       = (h_cnt == CNT_MAX);
  assign v_sat       = (v_cnt == CNT_MAX);
  assign frame_start = hs_lead && (vs_pend || vs_lead);
  assign h_meas      = h_cnt + CW'(1);
  assign v_meas      = v_cnt + CW'(1);
  assign h_cur       = hs_lead ? '0 : (h_sat ? CNT_MAX : h_meas);
  assign v_cur       = !hs_lead ? v_cnt : (frame_start ? '0 : (v_sat ? CNT_MAX : v_meas));

  // A saturated counter means the line had no measurable start, so it is not judged
  assign line_bad    = hs_lead && !h_sat && (h_meas != H_LEN);
  assign frame_good  = (v_meas == V_LEN) && !bad_seen && !line_bad;
  assign sync_loss   = (h_cur == CNT_MAX);
  assign in_win      = (h_cur >= H_FIRST) && (h_cur <= H_LAST) &&
                       (v_cur >= V_FIRST) && (v_cur <= V_LAST);
  assign err_evt     = (state != SEARCH) &&
                       (line_bad || sync_loss || (frame_start && !frame_good));

  // Lock state machine: next state
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    case (state)
      SEARCH: begin
        if (frame_start) begin
          state_nxt    = ACQUIRE;
          good_cnt_nxt = '0;
        end
      end
      ACQUIRE: begin
        if (sync_loss) begin
          state_nxt = SEARCH;
        end else if (frame_start) begin
          if (!frame_good) begin
            state_nxt = SEARCH;
          end else begin
            good_cnt_nxt = good_cnt + GC_W'(1);
            if (good_cnt_nxt == GC_LOCK) state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (line_bad || sync_loss || (frame_start && !frame_good)) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Lock state register
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
      locked   <= (state_nxt == LOCKED);
    end
  end

  // Pin capture, raster counters, timing measurement and output stage
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_hs_d     <= 1'b0;
      s1_vs_d     <= 1'b0;
      s1_rgb      <= '0;
      h_cnt       <= CNT_MAX;
      v_cnt       <= '0;
      vs_pend     <= 1'b0;
      bad_seen    <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      err         <= 1'b0;
      rx_x        <= '0;
      rx_y        <= '0;
      rx_de       <= 1'b0;
      rx_rgb      <= '0;
      probe_rgb   <= '0;
      probe_hit   <= 1'b0;
      probe_done  <= 1'b0;
    end else begin
      s1_hs   <= vga_hsync;
      s1_vs   <= vga_vsync;
      s1_hs_d <= s1_hs;
      s1_vs_d <= s1_vs;
      s1_rgb  <= {vga_r, vga_g, vga_b};
      h_cnt   <= h_cur;
      v_cnt   <= v_cur;

      if (hs_lead)      vs_pend <= 1'b0;
      else if (vs_lead) vs_pend <= 1'b1;

      if (hs_lead && !h_sat) line_len <= h_meas;

      if (frame_start) begin
        frame_lines <= v_meas;
        bad_seen    <= 1'b0;
      end else if (line_bad) begin
        bad_seen    <= 1'b1;
      end

      err <= err_evt || (err && !clr_err);

      rx_x   <= in_win ? h_cur - H_FIRST : '0;
      rx_y   <= in_win ? v_cur - V_FIRST : '0;
      rx_rgb <= in_win ? s1_rgb : '0;
      rx_de  <= in_win && (state == LOCKED);

      // One capture per frame, taken from the registered output pixel
      probe_hit <= 1'b0;
      if (frame_start) probe_done <= 1'b0;
      if (rx_de && (rx_x == probe_x) && (rx_y == probe_y) && !probe_done) begin
        probe_rgb  <= rx_rgb;
        probe_hit  <= 1'b1;
        probe_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced-size raster (same structure as 640x480).
module tb_vga_sync_receiver;

  localparam int H_ACTIVE = 32;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 8;
  localparam int H_TOTAL  = 56;
  localparam int V_ACTIVE = 6;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_TOTAL  = 12;
  localparam logic [11:0] BASE_RGB = 12'hF0F;

  logic        clk_vga = 1'b0;
  logic        rst_n, vga_hsync, vga_vsync, clr_err;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [9:0]  probe_x, probe_y;
  logic [9:0]  rx_x, rx_y, line_len, frame_lines;
  logic        rx_de, locked, probe_hit, err;
  logic [11:0] rx_rgb, probe_rgb;

  int errors = 0;
  int checks = 0;
  int hit_cnt = 0;
  int hit_base;
  int sp1_h = -1, sp1_v = -1, sp2_h = -1, sp2_v = -1;
  logic [11:0] sp1_rgb = 12'h000, sp2_rgb = 12'h000;

  vga_sync_receiver #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
    .SYNC_ACT(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .probe_x(probe_x), .probe_y(probe_y),
    .clr_err(clr_err), .rx_x(rx_x), .rx_y(rx_y), .rx_de(rx_de), .rx_rgb(rx_rgb),
    .locked(locked), .line_len(line_len), .frame_lines(frame_lines),
    .probe_rgb(probe_rgb), .probe_hit(probe_hit), .err(err)
  );

  always #5 clk_vga = ~clk_vga;

  always @(negedge clk_vga) if (probe_hit) hit_cnt++;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] all_out();
    return 80'({rx_x, rx_y, rx_de, rx_rgb, locked, line_len, frame_lines,
                probe_rgb, probe_hit, err});
  endfunction

  function automatic logic [11:0] colour(input int h, input int v);
    if (h == sp1_h && v == sp1_v) return sp1_rgb;
    if (h == sp2_h && v == sp2_v) return sp2_rgb;
    return BASE_RGB;
  endfunction

  // Drive one pixel, then return 1 time unit after the sampling edge
  task automatic tick(input logic hs, input logic vs, input logic [11:0] rgb);
    vga_hsync = hs;
    vga_vsync = vs;
    {vga_r, vga_g, vga_b} = rgb;
    @(posedge clk_vga);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 12'h000);
  endtask

  task automatic run_line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++)
      tick((h < H_SYNC) ? 1'b0 : 1'b1, (v < V_SYNC) ? 1'b0 : 1'b1, colour(h, v));
  endtask

  task automatic run_lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) run_line(v, 0, H_TOTAL - 1);
  endtask

  task automatic run_frame();
    run_lines(0, V_TOTAL - 1);
  endtask

  initial begin
    rst_n = 1'b0; clr_err = 1'b0; probe_x = '0; probe_y = '0;
    vga_hsync = 1'b1; vga_vsync = 1'b1; {vga_r, vga_g, vga_b} = 12'h000;
    idle(3);
    check("reset_outputs", all_out(), 80'd0);
    rst_n = 1'b1;
    idle(4);
    check("post_reset_outputs", all_out(), 80'd0);

    // Lock acquisition on nominal timing
    run_frame();
    run_frame();
    check("t1_locked_after_2nd_frame", 80'(locked), 80'd0);
    run_line(0, 0, 0);
    check("t1_locked_before_3rd_boundary", 80'(locked), 80'd0);
    run_line(0, 1, 1);
    check("t1_locked_at_3rd_boundary", 80'(locked), 80'd1);
    check("t1_line_len", 80'(line_len), 80'(H_TOTAL));
    check("t1_frame_lines", 80'(frame_lines), 80'(V_TOTAL));
    check("t1_err", 80'(err), 80'd0);
    run_line(0, 2, H_TOTAL - 1);
    run_lines(1, V_TOTAL - 1);

    // Pixel recovery and output latency
    sp1_h = 16; sp1_v = 4; sp1_rgb = 12'h123;
    sp2_h = 47; sp2_v = 9; sp2_rgb = 12'h456;
    run_lines(0, 3);
    run_line(4, 0, 16);
    check("t2_de_before_first_px", 80'(rx_de), 80'd0);
    run_line(4, 17, 17);
    check("t2_first_px", 80'({rx_x, rx_y, rx_de, rx_rgb}), 80'({10'd0, 10'd0, 1'b1, 12'h123}));
    run_line(4, 18, H_TOTAL - 1);
    run_lines(5, 8);
    run_line(9, 0, 48);
    check("t2_last_px", 80'({rx_x, rx_y, rx_de, rx_rgb}), 80'({10'd31, 10'd5, 1'b1, 12'h456}));
    run_line(9, 49, 49);
    check("t2_past_last_px", 80'({rx_x, rx_y, rx_de, rx_rgb}), 80'd0);
    run_line(9, 50, H_TOTAL - 1);
    run_lines(10, V_TOTAL - 1);

    // One long line while locked
    run_lines(0, 5);
    run_line(6, 0, H_TOTAL);
    run_line(7, 0, 0);
    check("t3_locked_before_lead", 80'(locked), 80'd1);
    check("t3_line_len_before", 80'(line_len), 80'(H_TOTAL));
    run_line(7, 1, 1);
    check("t3_unlocked", 80'(locked), 80'd0);
    check("t3_line_len_long", 80'(line_len), 80'(H_TOTAL + 1));
    check("t3_err_set", 80'(err), 80'd1);
    run_line(7, 2, H_TOTAL - 1);
    clr_err = 1'b1;
    run_line(8, 0, 0);
    clr_err = 1'b0;
    check("t3_err_cleared", 80'(err), 80'd0);
    run_line(8, 1, H_TOTAL - 1);
    run_lines(9, V_TOTAL - 1);
    check("t3_err_stays_clear", 80'(err), 80'd0);
    run_frame();
    run_frame();
    run_line(0, 0, 1);
    check("t3_relocked", 80'(locked), 80'd1);
    run_line(0, 2, H_TOTAL - 1);

    // Sync loss: hsync held inactive
    run_lines(1, 2);
    idle(968);
    check("t4_locked_before_loss", 80'({locked, err}), 80'({1'b1, 1'b0}));
    idle(1);
    check("t4_loss_detected", 80'({locked, err}), 80'({1'b0, 1'b1}));
    idle(131);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("t4_err_cleared", 80'(err), 80'd0);
    run_frame();
    run_frame();
    check("t4_not_locked_yet", 80'(locked), 80'd0);
    run_line(0, 0, 1);
    check("t4_relocked", 80'(locked), 80'd1);
    check("t4_frame_lines", 80'(frame_lines), 80'(V_TOTAL));
    run_line(0, 2, H_TOTAL - 1);
    run_lines(1, V_TOTAL - 1);

    // Probe capture
    probe_x = 10'd20; probe_y = 10'd3;
    sp1_h = 36; sp1_v = 7; sp1_rgb = 12'hABC;
    hit_base = hit_cnt;
    run_frame();
    check("t5_one_hit_frame1", 80'(hit_cnt - hit_base), 80'd1);
    check("t5_probe_rgb", 80'(probe_rgb), 80'(12'hABC));
    run_frame();
    check("t5_one_hit_frame2", 80'(hit_cnt - hit_base), 80'd2);
    probe_x = 10'd40; probe_y = 10'd0;
    run_frame();
    check("t5_out_of_range_no_hit", 80'(hit_cnt - hit_base), 80'd2);
    check("t5_probe_rgb_held", 80'(probe_rgb), 80'(12'hABC));

    // Asynchronous reset mid-frame
    run_lines(0, 4);
    check("t6_locked_before_reset", 80'(locked), 80'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset_outputs", all_out(), 80'd0);
    run_line(5, 0, 2);
    rst_n = 1'b1;
    run_line(5, 3, H_TOTAL - 1);
    run_lines(6, V_TOTAL - 1);
    run_frame();
    run_frame();
    check("t6_not_locked_after_1_good", 80'(locked), 80'd0);
    run_line(0, 0, 1);
    check("t6_relocked", 80'(locked), 80'd1);
    check("t6_frame_lines", 80'(frame_lines), 80'(V_TOTAL));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
